// File: rtl/mprj_bram_pkg.sv
// Shared types and constants for the mprjram arbiter slice.
package mprj_bram_pkg;

   typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_DONE} state_t;

   typedef enum logic {OWN_WB = 1'b0, OWN_DMA = 1'b1} owner_t;

   localparam logic [7:0] BASE_DEF = 8'h38;
   localparam int         LAT_W    = 4;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker; req[0] is Wishbone, req[1] is DMA.
module rr_arb2
   import mprj_bram_pkg::*;
(
   input  logic [1:0] req,
   input  owner_t     last,
   input  logic       en,
   output logic [1:0] gnt,
   output owner_t     last_nxt
);

   always_comb begin
      gnt      = 2'b00;
      last_nxt = last;
      if (en) begin
         // On a tie, Wishbone wins only if DMA was served last.
         if (req[0] && (!req[1] || last == OWN_DMA)) begin
            gnt      = 2'b01;
            last_nxt = OWN_WB;
         end else if (req[1]) begin
            gnt      = 2'b10;
            last_nxt = OWN_DMA;
         end
      end
   end

endmodule

// File: rtl/mprj_bram_arb.sv
// Serialises Wishbone and FIR DMA accesses onto the single-port mprjram,
// enforcing its fixed read latency with round-robin fairness.
module mprj_bram_arb
   import mprj_bram_pkg::*;
#(
   parameter int         ADDR_W = 10,
   parameter int         RD_LAT = 10,
   parameter logic [7:0] BASE   = BASE_DEF
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_i,
   input  logic              wbs_cyc_i,
   input  logic              wbs_stb_i,
   input  logic              wbs_we_i,
   input  logic [3:0]        wbs_sel_i,
   input  logic [31:0]       wbs_adr_i,
   input  logic [31:0]       wbs_dat_i,
   output logic              wbs_ack_o,
   output logic [31:0]       wbs_dat_o,
   input  logic              dma_req,
   input  logic              dma_we,
   input  logic [ADDR_W-1:0] dma_addr,
   input  logic [31:0]       dma_wdata,
   output logic              dma_gnt,
   output logic              dma_done,
   output logic [31:0]       dma_rdata,
   output logic              bram_en,
   output logic [3:0]        bram_we,
   output logic [ADDR_W-1:0] bram_addr,
   output logic [31:0]       bram_wdata,
   input  logic [31:0]       bram_rdata,
   output logic              busy
);

   state_t             state;
   owner_t             last;
   owner_t             own;
   owner_t             last_nxt;
   logic               rd_q;
   logic [LAT_W-1:0]   cnt;
   logic               wb_req;
   logic [1:0]         gnt;
   logic               unused_adr;

   assign wb_req     = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:24] == BASE);
   // Window bits above the BRAM depth are dropped so the address wraps.
   assign unused_adr = ^{wbs_adr_i[23:ADDR_W+2], wbs_adr_i[1:0]};
   assign busy       = (state != ST_IDLE);

   rr_arb2 u_arb (
      .req      ({dma_req, wb_req}),
      .last     (last),
      .en       (state == ST_IDLE),
      .gnt      (gnt),
      .last_nxt (last_nxt)
   );

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state      <= ST_IDLE;
         last       <= OWN_DMA;
         own        <= OWN_WB;
         rd_q       <= 1'b0;
         cnt        <= '0;
         wbs_ack_o  <= 1'b0;
         wbs_dat_o  <= '0;
         dma_gnt    <= 1'b0;
         dma_done   <= 1'b0;
         dma_rdata  <= '0;
         bram_en    <= 1'b0;
         bram_we    <= '0;
         bram_addr  <= '0;
         bram_wdata <= '0;
      end else begin
         wbs_ack_o  <= 1'b0;
         dma_gnt    <= 1'b0;
         dma_done   <= 1'b0;
         bram_en    <= 1'b0;
         bram_we    <= '0;
         bram_addr  <= '0;
         bram_wdata <= '0;
         case (state)
            ST_IDLE: begin
               // The BRAM outputs double as the latched request fields.
               if (|gnt) begin
                  last    <= last_nxt;
                  state   <= ST_ISSUE;
                  bram_en <= 1'b1;
                  if (gnt[1]) begin
                     own        <= OWN_DMA;
                     rd_q       <= ~dma_we;
                     dma_gnt    <= 1'b1;
                     bram_we    <= dma_we ? 4'hF : 4'h0;
                     bram_addr  <= dma_addr;
                     bram_wdata <= dma_wdata;
                  end else begin
                     own        <= OWN_WB;
                     rd_q       <= ~wbs_we_i;
                     bram_we    <= wbs_we_i ? wbs_sel_i : 4'h0;
                     bram_addr  <= wbs_adr_i[ADDR_W+1:2];
                     bram_wdata <= wbs_dat_i;
                  end
               end
            end
            ST_ISSUE: begin
               if (rd_q) begin
                  state <= ST_WAIT;
                  cnt   <= LAT_W'(RD_LAT - 1);
               end else begin
                  state <= ST_DONE;
                  if (own == OWN_WB) wbs_ack_o <= 1'b1;
                  else               dma_done  <= 1'b1;
               end
            end
            ST_WAIT: begin
               if (cnt == '0) begin
                  state <= ST_DONE;
                  if (own == OWN_WB) begin
                     wbs_dat_o <= bram_rdata;
                     wbs_ack_o <= 1'b1;
                  end else begin
                     dma_rdata <= bram_rdata;
                     dma_done  <= 1'b1;
                  end
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mprj_bram_arb.sv
// Randomised scoreboard bench for mprj_bram_arb with a latency-accurate BRAM model.
module tb_mprj_bram_arb;

   localparam int ADDR_W = 10;
   localparam int RD_LAT = 10;
   localparam int DEPTH  = 1 << ADDR_W;

   logic              wb_clk_i = 1'b0;
   logic              wb_rst_i;
   logic              wbs_cyc_i, wbs_stb_i, wbs_we_i;
   logic [3:0]        wbs_sel_i;
   logic [31:0]       wbs_adr_i, wbs_dat_i;
   logic              wbs_ack_o;
   logic [31:0]       wbs_dat_o;
   logic              dma_req, dma_we;
   logic [ADDR_W-1:0] dma_addr;
   logic [31:0]       dma_wdata;
   logic              dma_gnt, dma_done;
   logic [31:0]       dma_rdata;
   logic              bram_en;
   logic [3:0]        bram_we;
   logic [ADDR_W-1:0] bram_addr;
   logic [31:0]       bram_wdata, bram_rdata;
   logic              busy;

   mprj_bram_arb #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT), .BASE(8'h38)) dut (
      .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
      .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
      .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
      .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
      .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
      .dma_gnt(dma_gnt), .dma_done(dma_done), .dma_rdata(dma_rdata),
      .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
      .bram_wdata(bram_wdata), .bram_rdata(bram_rdata), .busy(busy)
   );

   always #5 wb_clk_i = ~wb_clk_i;

   int cyc = 0;
   always @(posedge wb_clk_i) cyc <= cyc + 1;

   // BRAM model: byte-enabled writes, read data valid exactly RD_LAT cycles after enable.
   logic [31:0]       mem [0:DEPTH-1];
   logic [31:0]       rd_dat [0:RD_LAT-1];
   logic              rd_vld [0:RD_LAT-1];
   logic              mem_init = 1'b0;
   logic [3:0]        last_we;
   logic [ADDR_W-1:0] last_addr;

   always @(posedge wb_clk_i) begin
      if (!mem_init) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= 32'h0;
         mem_init <= 1'b1;
      end else if (bram_en) begin
         for (int b = 0; b < 4; b++)
            if (bram_we[b]) mem[bram_addr][8*b +: 8] <= bram_wdata[8*b +: 8];
         last_we   <= bram_we;
         last_addr <= bram_addr;
      end
      rd_vld[0] <= bram_en && (bram_we == 4'h0);
      rd_dat[0] <= mem[bram_addr];
      for (int k = 1; k < RD_LAT; k++) begin
         rd_vld[k] <= rd_vld[k-1];
         rd_dat[k] <= rd_dat[k-1];
      end
   end
   assign bram_rdata = rd_vld[RD_LAT-1] ? rd_dat[RD_LAT-1] : 32'hBAD0_BAD0;

   // Reference contents of the array as the bench intends them to be.
   logic [31:0] ref_mem [0:DEPTH-1];

   typedef struct {
      logic        rd;
      logic [31:0] data;
      int          exp_cyc;
   } exp_t;

   exp_t wb_q[$];
   exp_t dma_q[$];
   int   done_order[$];
   int   gnt_log[$];

   int checks = 0;
   int failures = 0;
   int both_viol = 0;
   int idle_viol = 0;
   int gnt_cnt = 0;
   int ack_cnt = 0;
   int last_gnt_cyc = 0;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   function automatic logic outs_any();
      return |{wbs_ack_o, wbs_dat_o, dma_gnt, dma_done, dma_rdata,
               bram_en, bram_we, bram_addr, bram_wdata, busy};
   endfunction

   // Monitor: pops the owner's expectation whenever a completion appears.
   always @(negedge wb_clk_i) begin : monitor
      exp_t e;
      if (!wb_rst_i) begin
         if (wbs_ack_o && dma_done) both_viol++;
         if (!bram_en && (bram_we != 4'h0 || bram_addr != '0 || bram_wdata != 32'h0)) idle_viol++;
         if (dma_gnt) begin
            gnt_cnt++;
            last_gnt_cyc = cyc;
            gnt_log.push_back(cyc);
         end
         if (wbs_ack_o) begin
            ack_cnt++;
            done_order.push_back(0);
            if (wb_q.size() == 0) chk("wb_unexpected_ack", 32'd1, 32'd0);
            else begin
               e = wb_q.pop_front();
               if (e.rd) chk("wb_rdata", wbs_dat_o, e.data);
               if (e.exp_cyc >= 0) chk("wb_ack_cycle", 32'(cyc), 32'(e.exp_cyc));
            end
         end
         if (dma_done) begin
            done_order.push_back(1);
            if (dma_q.size() == 0) chk("dma_unexpected_done", 32'd1, 32'd0);
            else begin
               e = dma_q.pop_front();
               if (e.rd) chk("dma_rdata", dma_rdata, e.data);
               chk("dma_done_cycle", 32'(cyc), 32'(last_gnt_cyc + (e.rd ? RD_LAT + 1 : 1)));
            end
         end
      end
   end

   task automatic wb_access(input logic we, input logic [3:0] sel, input logic [31:0] adr,
                            input logic [31:0] dat, input logic timed);
      exp_t e;
      int   wa;
      bit   seen;
      wa = int'(adr[ADDR_W+1:2]);
      @(posedge wb_clk_i); #1;
      wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
      wbs_sel_i = sel;  wbs_adr_i = adr;  wbs_dat_i = dat;
      if (we)
         for (int b = 0; b < 4; b++)
            if (sel[b]) ref_mem[wa][8*b +: 8] = dat[8*b +: 8];
      e.rd      = !we;
      e.data    = ref_mem[wa];
      e.exp_cyc = timed ? cyc + (we ? 2 : 2 + RD_LAT) : -1;
      wb_q.push_back(e);
      seen = 0;
      for (int n = 0; n < 500 && !seen; n++) begin
         @(negedge wb_clk_i);
         if (wbs_ack_o) seen = 1;
      end
      if (!seen) chk("wb_ack_timeout", 32'd0, 32'd1);
      @(posedge wb_clk_i); #1;
      wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
   endtask

   // Back-to-back DMA accesses: the next request is presented the cycle after grant.
   task automatic dma_seq(input int n, input logic we, input int base, input logic rnd);
      exp_t e;
      bit   seen;
      for (int i = 0; i < n; i++) begin
         @(posedge wb_clk_i); #1;
         dma_req   = 1'b1;
         dma_we    = we;
         dma_addr  = ADDR_W'(base + i);
         dma_wdata = rnd ? $urandom : 32'(i);
         if (we) ref_mem[base + i] = dma_wdata;
         e.rd      = !we;
         e.data    = ref_mem[base + i];
         e.exp_cyc = -1;
         dma_q.push_back(e);
         seen = 0;
         for (int c = 0; c < 500 && !seen; c++) begin
            @(negedge wb_clk_i);
            if (dma_gnt) seen = 1;
         end
         if (!seen) chk("dma_gnt_timeout", 32'd0, 32'd1);
      end
      @(posedge wb_clk_i); #1;
      dma_req = 1'b0; dma_we = 1'b0;
   endtask

   task automatic wait_dma_idle();
      for (int c = 0; c < 100 && dma_q.size() != 0; c++) @(negedge wb_clk_i);
      chk("dma_drain", 32'(dma_q.size()), 32'd0);
   endtask

   initial begin : main
      int bad, a0, g0;
      int exp_order [4];
      exp_order = '{0, 1, 0, 1};
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h0;
      wb_rst_i = 1'b1;
      wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0; wbs_sel_i = 0; wbs_adr_i = 0; wbs_dat_i = 0;
      dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = 0;
      repeat (3) @(posedge wb_clk_i);
      #1;
      chk("reset_outputs", 32'(outs_any()), 32'd0);
      wb_rst_i = 1'b0;

      // Single write then read with latency checks.
      wb_access(1'b1, 4'hF, 32'h3800_0010, 32'hDEAD_BEEF, 1'b1);
      chk("wr_bram_addr", 32'(last_addr), 32'd4);
      chk("wr_bram_we", 32'(last_we), 32'hF);
      wb_access(1'b0, 4'hF, 32'h3800_0010, 32'h0, 1'b1);

      // Byte-lane write into a preloaded word.
      wb_access(1'b1, 4'hF, 32'h3800_0020, 32'h1122_3344, 1'b1);
      wb_access(1'b1, 4'b0010, 32'h3800_0020, 32'h0000_AB00, 1'b1);
      chk("byte_bram_we", 32'(last_we), 32'h2);
      wb_access(1'b0, 4'hF, 32'h3800_0020, 32'h0, 1'b1);

      // Address wraps inside the window.
      wb_access(1'b0, 4'hF, 32'h3800_1010, 32'h0, 1'b1);

      // Off-window request is ignored entirely.
      @(posedge wb_clk_i); #1;
      wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 0; wbs_adr_i = 32'h3000_0000;
      bad = 0;
      repeat (50) begin
         @(negedge wb_clk_i);
         if (bram_en || wbs_ack_o || busy) bad++;
      end
      chk("offwin_activity", 32'(bad), 32'd0);
      @(posedge wb_clk_i); #1;
      wbs_cyc_i = 0; wbs_stb_i = 0;

      // Simultaneous requests from reset alternate WB, DMA, WB, DMA.
      @(posedge wb_clk_i); #1;
      wb_rst_i = 1'b1;
      @(posedge wb_clk_i); #1;
      wb_rst_i = 1'b0;
      done_order.delete();
      fork
         begin
            wb_access(1'b1, 4'hF, 32'h3800_0100, $urandom, 1'b0);
            wb_access(1'b1, 4'hF, 32'h3800_0104, $urandom, 1'b0);
         end
         dma_seq(2, 1'b1, 600, 1'b1);
      join
      wait_dma_idle();
      chk("tie_count", 32'(done_order.size()), 32'd4);
      for (int i = 0; i < 4 && i < done_order.size(); i++)
         chk($sformatf("tie_order%0d", i), 32'(done_order[i]), 32'(exp_order[i]));
      wb_access(1'b0, 4'hF, 32'h3800_0104, 32'h0, 1'b1);
      dma_seq(2, 1'b0, 600, 1'b0);
      wait_dma_idle();

      // DMA stream: 64 writes at 3-cycle spacing, then readback.
      g0 = gnt_cnt;
      gnt_log.delete();
      dma_seq(64, 1'b1, 256, 1'b0);
      wait_dma_idle();
      chk("stream_gnt_count", 32'(gnt_cnt - g0), 32'd64);
      bad = 0;
      for (int k = 1; k < gnt_log.size(); k++)
         if (gnt_log[k] - gnt_log[k-1] != 3) bad++;
      chk("stream_spacing", 32'(bad), 32'd0);
      dma_seq(64, 1'b0, 256, 1'b0);
      wait_dma_idle();

      // Reset while a WB read sits in WAIT.
      @(posedge wb_clk_i); #1;
      wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 0; wbs_adr_i = 32'h3800_0010;
      repeat (5) @(posedge wb_clk_i);
      #3;
      wb_rst_i = 1'b1;
      #1;
      chk("midrst_outputs", 32'(outs_any()), 32'd0);
      @(posedge wb_clk_i); #1;
      wbs_cyc_i = 0; wbs_stb_i = 0;
      wb_rst_i = 1'b0;
      a0 = ack_cnt;
      repeat (20) @(posedge wb_clk_i);
      chk("midrst_no_ack", 32'(ack_cnt - a0), 32'd0);
      wb_access(1'b0, 4'hF, 32'h3800_0010, 32'h0, 1'b1);

      // Randomised concurrent traffic on disjoint address regions.
      fork
         for (int i = 0; i < 24; i++) begin
            logic [31:0] adr;
            adr = {8'h38, 12'($urandom), 2'b10, 8'($urandom), 2'b00};
            wb_access(1'($urandom), 4'($urandom_range(1, 15)), adr, $urandom, 1'b0);
            repeat ($urandom_range(0, 3)) @(posedge wb_clk_i);
         end
         for (int i = 0; i < 24; i++) begin
            dma_seq(1, 1'($urandom), 768 + $urandom_range(0, 255), 1'b1);
            repeat ($urandom_range(0, 3)) @(posedge wb_clk_i);
         end
      join
      wait_dma_idle();

      chk("wb_queue_empty", 32'(wb_q.size()), 32'd0);
      chk("ack_done_overlap", 32'(both_viol), 32'd0);
      chk("bram_idle_zero", 32'(idle_viol), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mprj_bram_arb.md
# mprj_bram_arb

Two-requester arbiter sharing the single-port user-project BRAM (mprjram, 0x3800_0000) between the management core's Wishbone slave port and the FIR accelerator's sample/result DMA port. It sits in the user project between the Wishbone decode and the BRAM macro. It serialises accesses, enforces the BRAM's fixed read latency, and uses round-robin fairness so that firmware running from mprjram (qsort, matmul) and FIR DMA traffic cannot starve each other.

## Interface
- `ADDR_W`, 10: BRAM word-address width (4 KB).
- `RD_LAT`, 10: cycles from BRAM enable to valid `bram_rdata`. Legal range 1..15.
- `BASE`, 8'h38: `wbs_adr_i[31:24]` value selecting mprjram.
- `wb_clk_i`  in  1  the single clock.
- `wb_rst_i`  in  1  asynchronous, active-high reset.
- `wbs_cyc_i`, `wbs_stb_i`, `wbs_we_i`  in  1  Wishbone classic request.
- `wbs_sel_i`  in  4  byte enables.
- `wbs_adr_i`  in  32  byte address.
- `wbs_dat_i`  in  32  write data.
- `wbs_ack_o`  out  1  one-cycle acknowledge.
- `wbs_dat_o`  out  32  read data, valid with ack.
- `dma_req`, `dma_we`  in  1  DMA request / write. DMA writes are full word.
- `dma_addr`  in  ADDR_W  word address.
- `dma_wdata`  in  32  write data.
- `dma_gnt`  out  1  request accepted; inputs may change next cycle.
- `dma_done`  out  1  access complete.
- `dma_rdata`  out  32  read data, valid with `dma_done`.
- `bram_en`  out  1  access strobe.
- `bram_we`  out  4  byte write enables.
- `bram_addr`  out  ADDR_W  word address.
- `bram_wdata`  out  32  BRAM write data.
- `bram_rdata`  in  32  BRAM read data.
- `busy`  out  1  state ≠ IDLE.

## Operation
- WB request valid when `wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:24]==BASE)`. Any other address is ignored: no ack, no BRAM access.
- Word address for WB is `wbs_adr_i[ADDR_W+1:2]`. Upper bits inside the window are ignored, so the address wraps.
- State machine:
  - IDLE: pick a requester → ISSUE.
  - ISSUE: drive the BRAM for one cycle. Write → DONE. Read → WAIT.
  - WAIT: count down RD_LAT cycles, then capture `bram_rdata` → DONE.
  - DONE: pulse ack/done → IDLE.
- Arbitration is round-robin on a `last` pointer.
  - Both requesting: grant the one not last served.
  - One requesting: grant it.
  - `last` updates on each grant. Reset value is `last`=DMA, so WB wins the first tie.
- Request fields are latched at grant (IDLE→ISSUE). Later changes to them do not affect the access in flight.
- WB writes use `bram_we = wbs_sel_i` when `wbs_we_i`, else 0. DMA writes use `bram_we = 4'hF`.
- `dma_gnt` is high in the ISSUE cycle of a DMA access. `dma_done` and `wbs_ack_o` are high in the DONE cycle of their own owner only.
- Outputs are registered. `bram_en`, `bram_we`, `bram_addr` and `bram_wdata` are nonzero only in ISSUE.
- Read data is held in `wbs_dat_o` / `dma_rdata` until the next read of that owner.
- Reset (async, any state) → IDLE. All outputs reset to 0 and `last`=DMA. An in-flight access is abandoned with no ack/done.

## Timing
- Request seen in IDLE cycle R. ISSUE is R+1. DONE is R+2 for a write and R+2+RD_LAT for a read.
- Back-to-back: the cycle after DONE is IDLE. Minimum spacing is 3 cycles per write and RD_LAT+3 per read.
- The WB master deasserts stb in the cycle after ack, so that IDLE never re-grants the completed transfer.
- Worst-case wait for a requester is one full access by the other requester.

## Structure
- Package `mprj_bram_pkg` holds:
  - the state enum (IDLE, ISSUE, WAIT, DONE);
  - the owner enum (OWN_WB, OWN_DMA);
  - the `BASE` default and a `LAT_W`=4 constant.
- Sub-module `rr_arb2` is the two-way round-robin picker. Inputs: `req[1:0]`, `last`, `en`. Outputs: `gnt[1:0]`, next `last`.

## Test plan
- **Single WB write then read:** write 0xDEADBEEF with sel=4'hF to 0x3800_0010, then read it back. Expect `bram_addr`=4, ack at R+2 for the write, ack at R+12 for the read (RD_LAT=10), and `wbs_dat_o`=0xDEADBEEF.
- **Byte write:** sel=4'b0010 with data 0x0000_AB00 to a word preloaded with 0x11223344. Expect `bram_we`=4'b0010 and a subsequent read of 0x1122AB44.
- **Simultaneous requests:** from reset, WB and DMA both request in the same cycle and both hold their requests. Expect grant order WB, DMA, WB, DMA; no ack and `dma_done` in the same cycle.
- **Off-window address:** WB read at 0x3000_0000. Expect no `bram_en` and no ack for 50 cycles, and `busy`=0.
- **DMA stream:** 64 sequential DMA writes of values i with the WB side idle. Expect exactly 64 `dma_gnt` pulses, a spacing of 3 cycles, and readback equal to i.
- **Reset mid-read:** assert `wb_rst_i` during WAIT. Expect all outputs 0 immediately, no ack after release, and the next WB request served normally.
